// File: rtl/riscv_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard and its writeback path.
package riscv_scoreboard_pkg;

  localparam int PCNT_W = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/riscv_scoreboard_wb_arb.sv
// Writeback arbiter (mem fixed priority over ALU) feeding a registered register-file write port.
module riscv_wb_arb
  import riscv_scoreboard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGA = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            mem_wb_valid,
  input  logic [REGA-1:0] mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  input  logic            alu_wb_valid,
  input  logic [REGA-1:0] alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,
  output logic            rf_we,
  output logic [REGA-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  // A source transfers when valid && ready in the same cycle; mem has no ready
  // because it is always accepted, so the ALU only gets ready when mem is idle.
  wb_src_e         src;
  logic [REGA-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            rf_we_d, rf_we_q;
  logic [REGA-1:0] rf_waddr_d, rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_d, rf_wdata_q;

  assign alu_wb_ready = !mem_wb_valid;

  always_comb begin
    src      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (mem_wb_valid) begin
      src      = SRC_MEM;
      sel_rd   = mem_wb_rd;
      sel_data = mem_wb_data;
    end else if (alu_wb_valid) begin
      src      = SRC_ALU;
      sel_rd   = alu_wb_rd;
      sel_data = alu_wb_data;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (src != SRC_NONE && !flush) begin
      rf_we_d    = (sel_rd != '0);
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: rtl/riscv_scoreboard.sv
// Register scoreboard: tracks pending destination registers, gates issue on hazards
// and capacity, and retires pending bits when the register file is written.
module riscv_scoreboard
  import riscv_scoreboard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REGA  = 5,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REGA-1:0]   id_rs1,
  input  logic [REGA-1:0]   id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REGA-1:0]   id_rd,
  input  logic              id_writes_rd,
  output logic              issue_ready,
  input  logic              mem_wb_valid,
  input  logic [REGA-1:0]   mem_wb_rd,
  input  logic [XLEN-1:0]   mem_wb_data,
  input  logic              alu_wb_valid,
  input  logic [REGA-1:0]   alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  output logic              alu_wb_ready,
  output logic              rf_we,
  output logic [REGA-1:0]   rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic              flush,
  output logic [PCNT_W-1:0] pending_count,
  output logic              sb_error
);

  localparam int NREG = 1 << REGA;
  localparam logic [REGA:0] DEPTH_V = (REGA + 1)'(DEPTH);

  logic [NREG-1:0] pending_d, pending_q;
  logic            sb_error_d, sb_error_q;
  logic [REGA:0]   cnt;
  logic            hazard, issue_fire, commit_ok;

  riscv_wb_arb #(.XLEN(XLEN), .REGA(REGA)) u_wb_arb (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_data  (mem_wb_data),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREG; i++) cnt = cnt + (REGA + 1)'(pending_q[i]);
  end

  // Hazards look only at registered pending bits: a commit becomes visible the cycle after rf_we.
  always_comb begin
    hazard = (id_use_rs1   && id_rs1 != '0 && pending_q[id_rs1]) ||
             (id_use_rs2   && id_rs2 != '0 && pending_q[id_rs2]) ||
             (id_writes_rd && id_rd  != '0 && pending_q[id_rd]);
    issue_ready = !hazard && !flush &&
                  (cnt < DEPTH_V || !id_writes_rd || id_rd == '0);
  end

  assign issue_fire = id_valid && issue_ready && id_writes_rd && id_rd != '0;
  assign commit_ok  = pending_q[rf_waddr];

  always_comb begin
    pending_d  = pending_q;
    sb_error_d = sb_error_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (rf_we) begin
        if (commit_ok) pending_d[rf_waddr] = 1'b0;
        else           sb_error_d = 1'b1;
      end
      if (issue_fire) pending_d[id_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      sb_error_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      sb_error_q <= sb_error_d;
    end
  end

  assign pending_count = cnt[PCNT_W-1:0];
  assign sb_error      = sb_error_q;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Self-checking bench for riscv_scoreboard: directed scenarios, then a randomized
// run against a small reference model of the pending set.
module tb_riscv_scoreboard;

  localparam int XLEN  = 32;
  localparam int REGA  = 5;
  localparam int DEPTH = 4;

  logic            clk, rst;
  logic            id_valid, id_use_rs1, id_use_rs2, id_writes_rd;
  logic [REGA-1:0] id_rs1, id_rs2, id_rd;
  logic            issue_ready;
  logic            mem_wb_valid, alu_wb_valid, alu_wb_ready;
  logic [REGA-1:0] mem_wb_rd, alu_wb_rd;
  logic [XLEN-1:0] mem_wb_data, alu_wb_data;
  logic            rf_we;
  logic [REGA-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            flush;
  logic [2:0]      pending_count;
  logic            sb_error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [REGA+XLEN-1:0] exp_q[$];
  logic [REGA+XLEN-1:0] e;

  // reference model state for the random phase
  bit [31:0]       m_pend, nxt;
  bit              m_we, n_we, fire, hz, exp_rdy;
  logic [REGA-1:0] m_wa, n_wa;
  logic [REGA-1:0] infl[$];
  int              mi, ai, sel;

  riscv_scoreboard #(.XLEN(XLEN), .REGA(REGA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_writes_rd(id_writes_rd), .issue_ready(issue_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .pending_count(pending_count), .sb_error(sb_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_writes_rd = 0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    mem_wb_valid = 0; mem_wb_rd = '0; mem_wb_data = '0;
    alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    flush = 0;
  endtask

  task automatic issue_one(input logic [REGA-1:0] rd);
    id_valid = 1; id_writes_rd = 1; id_rd = rd; id_use_rs1 = 0; id_use_rs2 = 0;
    #1 chk($sformatf("issue_rd%0d_ready", rd), 64'(issue_ready), 64'(1));
    step();
    id_valid = 0; id_writes_rd = 0;
  endtask

  task automatic wb_mem(input logic [REGA-1:0] rd, input logic [XLEN-1:0] d);
    mem_wb_valid = 1; mem_wb_rd = rd; mem_wb_data = d;
    step();
    mem_wb_valid = 0;
    step();
  endtask

  // scoreboard: writes predicted from the requests seen on the previous edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("rf_we", 64'(rf_we), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rf_waddr", 64'(rf_waddr), 64'(e[REGA+XLEN-1:XLEN]));
        chk("rf_wdata", 64'(rf_wdata), 64'(e[XLEN-1:0]));
      end
      if (!flush) begin
        if (mem_wb_valid) begin
          if (mem_wb_rd != '0) exp_q.push_back({mem_wb_rd, mem_wb_data});
        end else if (alu_wb_valid && alu_wb_rd != '0) begin
          exp_q.push_back({alu_wb_rd, alu_wb_data});
        end
      end
    end
  end

  initial begin
    rst = 1;
    idle();
    #2;
    chk("rst_pending_count", 64'(pending_count), 64'(0));
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_sb_error", 64'(sb_error), 64'(0));
    chk("rst_issue_ready", 64'(issue_ready), 64'(1));
    step(); step();
    rst = 0;
    step();

    // RAW hazard on rd=5 held until the cycle after its commit
    id_valid = 1; id_writes_rd = 1; id_rd = 5; id_use_rs1 = 1; id_rs1 = 0;
    #1 chk("raw_first_ready", 64'(issue_ready), 64'(1));
    step();
    id_rs1 = 5; id_rd = 6;
    #1 chk("raw_stall0", 64'(issue_ready), 64'(0));
    chk("raw_count", 64'(pending_count), 64'(1));
    step();
    #1 chk("raw_stall1", 64'(issue_ready), 64'(0));
    mem_wb_valid = 1; mem_wb_rd = 5; mem_wb_data = 32'h0000_00a5;
    step();
    mem_wb_valid = 0;
    #1 chk("raw_commit_we", 64'(rf_we), 64'(1));
    chk("raw_commit_addr", 64'(rf_waddr), 64'(5));
    chk("raw_stall_commit", 64'(issue_ready), 64'(0));
    step();
    #1 chk("raw_release", 64'(issue_ready), 64'(1));
    step();
    id_valid = 0; id_writes_rd = 0; id_use_rs1 = 0;
    #1 chk("raw_count_rd6", 64'(pending_count), 64'(1));
    wb_mem(6, 32'h66);
    chk("raw_drain_count", 64'(pending_count), 64'(0));

    // mem beats ALU when both request
    issue_one(3); issue_one(4);
    mem_wb_valid = 1; mem_wb_rd = 3; mem_wb_data = 32'h3333;
    alu_wb_valid = 1; alu_wb_rd = 4; alu_wb_data = 32'h4444;
    #1 chk("arb_alu_blocked", 64'(alu_wb_ready), 64'(0));
    step();
    mem_wb_valid = 0;
    #1 chk("arb_mem_first", 64'(rf_waddr), 64'(3));
    chk("arb_alu_granted", 64'(alu_wb_ready), 64'(1));
    step();
    alu_wb_valid = 0;
    #1 chk("arb_alu_second", 64'(rf_waddr), 64'(4));
    step();
    chk("arb_drain_count", 64'(pending_count), 64'(0));

    // capacity limit
    for (int r = 1; r <= 4; r++) issue_one(REGA'(r));
    #1 chk("full_count", 64'(pending_count), 64'(4));
    id_valid = 0; id_writes_rd = 1; id_rd = 6;
    #1 chk("full_writer_blocked", 64'(issue_ready), 64'(0));
    id_rd = 0;
    #1 chk("full_rd0_ok", 64'(issue_ready), 64'(1));
    id_valid = 1; id_writes_rd = 0; id_use_rs1 = 1; id_rs1 = 8; id_use_rs2 = 1; id_rs2 = 9;
    #1 chk("full_store_ok", 64'(issue_ready), 64'(1));
    step();
    idle();
    #1 chk("full_store_count", 64'(pending_count), 64'(4));

    // same-cycle commit of rd=2 and issue of rd=7
    wb_mem(1, 32'h11);
    chk("pre_swap_count", 64'(pending_count), 64'(3));
    mem_wb_valid = 1; mem_wb_rd = 2; mem_wb_data = 32'h22;
    step();
    mem_wb_valid = 0;
    id_valid = 1; id_writes_rd = 1; id_rd = 7;
    #1 chk("swap_ready", 64'(issue_ready), 64'(1));
    step();
    idle();
    #1 chk("swap_count", 64'(pending_count), 64'(3));
    id_use_rs1 = 1; id_rs1 = 2;
    #1 chk("swap_rd2_clear", 64'(issue_ready), 64'(1));
    id_rs1 = 7;
    #1 chk("swap_rd7_set", 64'(issue_ready), 64'(0));
    idle();

    // flush with pending work and a granted write, then a stray commit
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 32'h3030; flush = 1;
    #1 chk("flush_ready", 64'(issue_ready), 64'(0));
    chk("flush_alu_ready", 64'(alu_wb_ready), 64'(1));
    step();
    idle();
    #1 chk("flush_count", 64'(pending_count), 64'(0));
    chk("flush_rf_we", 64'(rf_we), 64'(0));
    alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'h9999;
    step();
    alu_wb_valid = 0;
    #1 chk("stray_we", 64'(rf_we), 64'(1));
    chk("stray_err_before", 64'(sb_error), 64'(0));
    step();
    chk("stray_err_set", 64'(sb_error), 64'(1));
    chk("stray_count", 64'(pending_count), 64'(0));
    step();
    chk("stray_err_sticky", 64'(sb_error), 64'(1));

    // reset mid-operation discards an in-flight write
    issue_one(10);
    mem_wb_valid = 1; mem_wb_rd = 10; mem_wb_data = 32'habcd;
    step();
    mem_wb_valid = 0;
    #1 chk("mid_rst_we_before", 64'(rf_we), 64'(1));
    rst = 1;
    #1 chk("mid_rst_we", 64'(rf_we), 64'(0));
    chk("mid_rst_count", 64'(pending_count), 64'(0));
    chk("mid_rst_err", 64'(sb_error), 64'(0));
    chk("mid_rst_waddr", 64'(rf_waddr), 64'(0));
    chk("mid_rst_wdata", 64'(rf_wdata), 64'(0));
    step(); step();
    rst = 0;
    step();
    chk("post_rst_count", 64'(pending_count), 64'(0));

    // writeback to x0
    mem_wb_valid = 1; mem_wb_rd = 0; mem_wb_data = 32'hdead;
    #1 chk("x0_alu_ready", 64'(alu_wb_ready), 64'(0));
    step();
    mem_wb_valid = 0;
    #1 chk("x0_rf_we", 64'(rf_we), 64'(0));
    step();
    chk("x0_err", 64'(sb_error), 64'(0));
    chk("x0_count", 64'(pending_count), 64'(0));

    // randomized phase against the reference model
    m_pend = '0; m_we = 0; m_wa = '0;
    infl.delete();
    for (int c = 0; c < 400; c++) begin
      idle();
      id_valid     = 1'($urandom_range(0, 1));
      id_rs1       = REGA'($urandom_range(0, 11));
      id_rs2       = REGA'($urandom_range(0, 11));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      id_rd        = REGA'($urandom_range(0, 11));
      id_writes_rd = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 39) == 0);
      mi = -1; ai = -1;
      if (infl.size() > 0 && $urandom_range(0, 2) != 0) begin
        sel = $urandom_range(0, 2);
        if (sel == 2 && infl.size() < 2) sel = 0;
        mi = (sel != 1) ? $urandom_range(0, infl.size() - 1) : -1;
        if (sel == 1) ai = $urandom_range(0, infl.size() - 1);
        if (sel == 2) ai = (mi + 1) % infl.size();
        if (mi >= 0) begin
          mem_wb_valid = 1; mem_wb_rd = infl[mi]; mem_wb_data = $urandom;
        end
        if (ai >= 0) begin
          alu_wb_valid = 1; alu_wb_rd = infl[ai]; alu_wb_data = $urandom;
        end
      end
      #1;
      hz = (id_use_rs1 && id_rs1 != 0 && m_pend[id_rs1]) ||
           (id_use_rs2 && id_rs2 != 0 && m_pend[id_rs2]) ||
           (id_writes_rd && id_rd != 0 && m_pend[id_rd]);
      exp_rdy = !hz && !flush &&
                ($countones(m_pend) < DEPTH || !id_writes_rd || id_rd == 0);
      chk("rnd_ready", 64'(issue_ready), 64'(exp_rdy));
      chk("rnd_count", 64'(pending_count), 64'($countones(m_pend)));
      chk("rnd_alu_ready", 64'(alu_wb_ready), 64'(!mem_wb_valid));
      chk("rnd_err", 64'(sb_error), 64'(0));
      fire = id_valid && exp_rdy && id_writes_rd && id_rd != 0;
      nxt = m_pend;
      n_we = 0; n_wa = m_wa;
      if (flush) begin
        nxt = '0;
        infl.delete();
      end else begin
        if (m_we && m_pend[m_wa]) nxt[m_wa] = 0;
        if (fire) nxt[id_rd] = 1;
        if (mem_wb_valid) begin
          n_we = 1; n_wa = mem_wb_rd;
          infl.delete(mi);
        end else if (alu_wb_valid) begin
          n_we = 1; n_wa = alu_wb_rd;
          infl.delete(ai);
        end
        if (fire) infl.push_back(id_rd);
      end
      step();
      m_pend = nxt; m_we = n_we; m_wa = n_wa;
    end

    idle();
    step(); step(); step();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
